// File: rtl/sdr_init_seq.sv
// SDRAM power-up/initialisation sequencer: drives the SDRAM command bus from reset
// through PRECHARGE, AUTO-REFRESH and LOAD-MODE, then flags sdr_init_done.
module sdr_init_seq #(
    parameter logic [15:0] POWERUP_CYC = 16'd20000,
    parameter int unsigned REF_CNT     = 2,
    parameter int unsigned TMRD        = 2,
    parameter int unsigned SDR_ADDR_W  = 13
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_reset,
    input  logic                  cfg_sdr_en,
    input  logic [3:0]            cfg_sdr_trp_d,
    input  logic [3:0]            cfg_sdr_trcar_d,
    input  logic [12:0]           cfg_sdr_mode_reg,
    output logic                  sdr_init_done,
    output logic                  sdr_cke,
    output logic                  sdr_cs_n,
    output logic                  sdr_ras_n,
    output logic                  sdr_cas_n,
    output logic                  sdr_we_n,
    output logic [1:0]            sdr_ba,
    output logic [SDR_ADDR_W-1:0] sdr_addr
);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_LMR   = 4'b0000;

    localparam logic [15:0] MRD_CYC = (TMRD == 0) ? 16'd1 : 16'(TMRD);

    typedef enum logic [3:0] {
        StIdle, StPwrup, StPre, StWaitTrp, StAref, StWaitTrcar, StLmr, StWaitMrd, StDone
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            ref_q, ref_d;
    logic                  cke_q, cke_d;
    logic [3:0]            cmd_q, cmd_d;
    logic [1:0]            ba_q, ba_d;
    logic [SDR_ADDR_W-1:0] addr_q, addr_d;
    logic                  done_q, done_d;
    logic                  go_pre, go_aref, go_lmr;

    // Zero spacing is treated as one cycle.
    function automatic logic [15:0] spacing(input logic [3:0] v);
        return (v == 4'd0) ? 16'd1 : {12'd0, v};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ref_d   = ref_q;
        cke_d   = 1'b1;
        cmd_d   = CMD_NOP;
        ba_d    = 2'b00;
        addr_d  = '0;
        done_d  = 1'b0;
        go_pre  = 1'b0;
        go_aref = 1'b0;
        go_lmr  = 1'b0;

        if (!cfg_sdr_en) begin
            state_d = StIdle;
            cnt_d   = '0;
            ref_d   = '0;
            cke_d   = 1'b0;
            cmd_d   = CMD_DESEL;
        end else begin
            // cnt_q holds cycles left until the next command lands; 1 means "now".
            unique case (state_q)
                StIdle: begin
                    state_d = StPwrup;
                    cnt_d   = 16'd1;
                end
                StPwrup: begin
                    if (cnt_q >= POWERUP_CYC) go_pre = 1'b1;
                    else if (cnt_q != 16'hffff) cnt_d = cnt_q + 16'd1;
                end
                StPre, StWaitTrp: begin
                    if (cnt_q <= 16'd1) begin
                        if (ref_q != 8'd0) go_aref = 1'b1;
                        else go_lmr = 1'b1;
                    end else begin
                        state_d = StWaitTrp;
                        cnt_d   = cnt_q - 16'd1;
                    end
                end
                StAref, StWaitTrcar: begin
                    if (cnt_q <= 16'd1) begin
                        if (ref_q != 8'd0) go_aref = 1'b1;
                        else go_lmr = 1'b1;
                    end else begin
                        state_d = StWaitTrcar;
                        cnt_d   = cnt_q - 16'd1;
                    end
                end
                StLmr, StWaitMrd: begin
                    if (cnt_q <= 16'd1) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StWaitMrd;
                        cnt_d   = cnt_q - 16'd1;
                    end
                end
                StDone:  done_d = 1'b1;
                default: state_d = StIdle;
            endcase

            if (go_pre) begin
                state_d    = StPre;
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
                cnt_d      = spacing(cfg_sdr_trp_d);
                ref_d      = 8'(REF_CNT);
            end
            if (go_aref) begin
                state_d = StAref;
                cmd_d   = CMD_AREF;
                cnt_d   = spacing(cfg_sdr_trcar_d);
                ref_d   = ref_q - 8'd1;
            end
            if (go_lmr) begin
                state_d = StLmr;
                cmd_d   = CMD_LMR;
                addr_d  = SDR_ADDR_W'(cfg_sdr_mode_reg);
                cnt_d   = MRD_CYC;
            end
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ref_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_DESEL;
            ba_q    <= 2'b00;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cke_q   <= cke_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    assign sdr_init_done = done_q;
    assign sdr_cke       = cke_q;
    assign sdr_cs_n      = cmd_q[3];
    assign sdr_ras_n     = cmd_q[2];
    assign sdr_cas_n     = cmd_q[1];
    assign sdr_we_n      = cmd_q[0];
    assign sdr_ba        = ba_q;
    assign sdr_addr      = addr_q;

endmodule
